// File: rtl/mmu_8722.sv
// 8722 MMU: CPU-visible config registers ($D500-$D50B, $FF00-$FF04), PLA mode outputs, DRAM bank/relocation.
// Register reads are combinational; writes commit on the clock edge; no backpressure (one access per cycle).
module mmu_8722 #(
    parameter logic [7:0] VERSION = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    input  logic        rw,
    input  logic        aec,
    input  logic        iocs,
    input  logic        game,
    input  logic        exrom,
    input  logic        sw4080,
    output logic [7:0]  dout,
    output logic        doe,
    output logic        ms0,
    output logic        ms1,
    output logic        ms2,
    output logic        ms3,
    output logic        z80en,
    output logic        fsdir,
    output logic [1:0]  ram_bank,
    output logic [7:0]  ta,
    output logic [1:0]  vic_bank
);

    logic [7:0] r_cr;
    logic [7:0] r_pcr [4];
    logic       r_z80sel;
    logic       r_fsdir;
    logic       r_c64;
    logic [7:0] r_rcr;
    logic [7:0] r_p0l;
    logic [7:0] r_p0h;
    logic [7:0] r_p1l;
    logic [7:0] r_p1h;
    logic [7:0] r_p0h_sh;
    logic [7:0] r_p1h_sh;

    logic       w_d5_hit;
    logic       w_ff_hit;
    logic       w_d5_wr;
    logic       w_ff_wr;
    logic       w_rd;
    logic [1:0] w_pcr_idx;
    logic [7:0] w_mcr_rd;
    logic [7:0] w_page;
    logic [15:0] w_cmn_mask;
    logic       w_cmn_bot;
    logic       w_cmn_top;
    logic       w_cmn_hit;

    // Once the machine drops into C64 mode the whole register file vanishes from the bus.
    assign w_d5_hit  = iocs && (a[11:8] == 4'h5) && (a[7:0] <= 8'h0B) && !r_c64;
    assign w_ff_hit  = (a[15:3] == 13'h1FE0) && (a[2:0] <= 3'd4) && !r_c64;
    assign w_d5_wr   = aec && !rw && w_d5_hit;
    assign w_ff_wr   = aec && !rw && w_ff_hit;
    assign w_rd      = aec && rw && (w_d5_hit || w_ff_hit);
    // Offsets 1..4 map to PCR 0..3 for both windows ($D501-4, $FF01-4); offset 4 wraps to 3.
    assign w_pcr_idx = a[1:0] - 2'd1;

    assign w_mcr_rd  = {sw4080, r_c64, exrom, game, r_fsdir, 1'b1, 1'b1, r_z80sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cr     <= 8'h00;
            for (int i = 0; i < 4; i++) r_pcr[i] <= 8'h00;
            r_z80sel <= 1'b0;
            r_fsdir  <= 1'b0;
            r_c64    <= 1'b0;
            r_rcr    <= 8'h00;
            r_p0l    <= 8'h00;
            r_p0h    <= 8'h00;
            r_p1l    <= 8'h01;
            r_p1h    <= 8'h00;
            r_p0h_sh <= 8'h00;
            r_p1h_sh <= 8'h00;
        end else if (w_d5_wr) begin
            case (a[3:0])
                4'h0: r_cr <= din;
                4'h1, 4'h2, 4'h3, 4'h4: r_pcr[w_pcr_idx] <= din;
                4'h5: begin
                    r_z80sel <= din[0];
                    r_fsdir  <= din[3];
                    r_c64    <= din[6];
                end
                4'h6: r_rcr <= din;
                // High byte is staged so a pointer never points at a half-updated page.
                4'h7: begin
                    r_p0l <= din;
                    r_p0h <= r_p0h_sh;
                end
                4'h8: r_p0h_sh <= din;
                4'h9: begin
                    r_p1l <= din;
                    r_p1h <= r_p1h_sh;
                end
                4'hA: r_p1h_sh <= din;
                default: ;
            endcase
        end else if (w_ff_wr) begin
            if (a[2:0] == 3'd0) r_cr <= din;
            else                r_cr <= r_pcr[w_pcr_idx];
        end
    end

    always_comb begin
        dout = 8'h00;
        doe  = 1'b0;
        if (w_rd) begin
            doe = 1'b1;
            if (w_d5_hit) begin
                case (a[3:0])
                    4'h0:                   dout = r_cr;
                    4'h1, 4'h2, 4'h3, 4'h4: dout = r_pcr[w_pcr_idx];
                    4'h5:                   dout = w_mcr_rd;
                    4'h6:                   dout = r_rcr;
                    4'h7:                   dout = r_p0l;
                    4'h8:                   dout = r_p0h;
                    4'h9:                   dout = r_p1l;
                    4'hA:                   dout = r_p1h;
                    default:                dout = VERSION;
                endcase
            end else if (a[2:0] == 3'd0) begin
                dout = r_cr;
            end else begin
                dout = r_pcr[w_pcr_idx];
            end
        end
    end

    always_comb begin
        case (a[15:14])
            2'b01:   {ms1, ms0} = {r_cr[1], r_cr[1]};
            2'b10:   {ms1, ms0} = r_cr[3:2];
            2'b11:   {ms1, ms0} = r_cr[5:4];
            default: {ms1, ms0} = 2'b11;
        endcase
    end

    assign ms2      = r_cr[0];
    assign ms3      = ~r_c64;
    assign z80en    = ~r_z80sel;
    assign fsdir    = r_fsdir;
    assign vic_bank = r_rcr[7:6];

    always_comb begin
        case (r_rcr[1:0])
            2'd0:    w_cmn_mask = 16'hFC00;
            2'd1:    w_cmn_mask = 16'hF000;
            2'd2:    w_cmn_mask = 16'hE000;
            default: w_cmn_mask = 16'hC000;
        endcase
    end

    assign w_cmn_bot = r_rcr[2] && ((a & w_cmn_mask) == 16'h0000);
    assign w_cmn_top = r_rcr[3] && ((a & w_cmn_mask) == w_cmn_mask);
    assign w_cmn_hit = w_cmn_bot || w_cmn_top;
    assign w_page    = a[15:8];

    // Relocation swaps the target page with page 0/1 only when it lives in the active bank.
    always_comb begin
        ta       = w_page;
        ram_bank = r_cr[7:6];
        if (w_page == 8'h00) begin
            ta       = r_p0l;
            ram_bank = r_p0h[1:0];
        end else if ((w_page == r_p0l) && (r_p0h[1:0] == r_cr[7:6])) begin
            ta = 8'h00;
        end else if (w_page == 8'h01) begin
            ta       = r_p1l;
            ram_bank = r_p1h[1:0];
        end else if ((w_page == r_p1l) && (r_p1h[1:0] == r_cr[7:6])) begin
            ta = 8'h01;
        end
        if (w_cmn_hit) ram_bank = 2'b00;
    end

endmodule

// File: tb/tb_mmu_8722.sv
// Directed bench for mmu_8722: register access, LCR, page pointers, common RAM, C64 lockout.
module tb_mmu_8722;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic [7:0]  din;
    logic        rw;
    logic        aec;
    logic        iocs;
    logic        game;
    logic        exrom;
    logic        sw4080;
    logic [7:0]  dout;
    logic        doe;
    logic        ms0, ms1, ms2, ms3, z80en, fsdir;
    logic [1:0]  ram_bank;
    logic [7:0]  ta;
    logic [1:0]  vic_bank;

    int checks = 0;
    int errors = 0;

    mmu_8722 #(.VERSION(8'h20)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .din(din), .rw(rw), .aec(aec),
        .iocs(iocs), .game(game), .exrom(exrom), .sw4080(sw4080),
        .dout(dout), .doe(doe), .ms0(ms0), .ms1(ms1), .ms2(ms2), .ms3(ms3),
        .z80en(z80en), .fsdir(fsdir), .ram_bank(ram_bank), .ta(ta), .vic_bank(vic_bank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data, input logic io, input logic en);
        a = addr; din = data; iocs = io; rw = 1'b0; aec = en;
        @(posedge clk); #1;
        rw = 1'b1; aec = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic io);
        a = addr; iocs = io; rw = 1'b1; aec = 1'b1;
        #2;
    endtask

    task automatic acc(input logic [15:0] addr);
        a = addr; iocs = 1'b0; rw = 1'b1; aec = 1'b0;
        #2;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0; #3; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; a = 16'h0000; din = 8'h00; rw = 1'b1; aec = 1'b0; iocs = 1'b0;
        game = 1'b1; exrom = 1'b1; sw4080 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ms3", 16'(ms3), 16'h1);
        chk("rst_z80en", 16'(z80en), 16'h1);
        chk("rst_ms2", 16'(ms2), 16'h0);
        chk("rst_bank", 16'(ram_bank), 16'h0);
        chk("rst_vic", 16'(vic_bank), 16'h0);
        chk("rst_fsdir", 16'(fsdir), 16'h0);
        chk("rst_doe", 16'(doe), 16'h0);
        chk("rst_dout", 16'(dout), 16'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd(16'hD505, 1'b1);
        chk("mcr_rd", 16'(dout), 16'h36);
        chk("mcr_doe", 16'(doe), 16'h1);

        // LCR preconfig load
        wr(16'hD501, 8'h3F, 1'b1, 1'b1);
        wr(16'hFF01, 8'h00, 1'b0, 1'b1);
        rd(16'hFF00, 1'b0);
        chk("lcr_cr", 16'(dout), 16'h3F);
        rd(16'hFF01, 1'b0);
        chk("lcr_pcr_rd", 16'(dout), 16'h3F);
        acc(16'hC123);
        chk("c123_ms10", 16'({ms1, ms0}), 16'h3);
        chk("c123_ms2", 16'(ms2), 16'h1);

        // Mode decode per address window
        wr(16'hD500, 8'h0A, 1'b1, 1'b1);
        acc(16'h5000); chk("m_5000", 16'({ms1, ms0}), 16'h3);
        acc(16'h9000); chk("m_9000", 16'({ms1, ms0}), 16'h2);
        acc(16'hE000); chk("m_e000", 16'({ms1, ms0}), 16'h0);
        acc(16'h1000); chk("m_1000", 16'({ms1, ms0}), 16'h3);
        chk("m_ms2", 16'(ms2), 16'h0);
        wr(16'hFF00, 8'hFF, 1'b0, 1'b0);
        rd(16'hD500, 1'b1);
        chk("aec0_ignored", 16'(dout), 16'h0A);
        wr(16'hD500, 8'h00, 1'b1, 1'b1);

        // Page pointer shadowing and relocation
        wr(16'hD508, 8'h02, 1'b1, 1'b1);
        rd(16'hD508, 1'b1); chk("p0h_shadow", 16'(dout), 16'h00);
        wr(16'hD507, 8'h40, 1'b1, 1'b1);
        rd(16'hD508, 1'b1); chk("p0h_commit", 16'(dout), 16'h02);
        rd(16'hD507, 1'b1); chk("p0l_rd", 16'(dout), 16'h40);
        acc(16'h0012);
        chk("p0_ta", 16'(ta), 16'h40);
        chk("p0_bank", 16'(ram_bank), 16'h2);
        acc(16'h4012);
        chk("swap_nobank_ta", 16'(ta), 16'h40);
        chk("swap_nobank_bk", 16'(ram_bank), 16'h0);
        wr(16'hD500, 8'h80, 1'b1, 1'b1);
        acc(16'h4012);
        chk("swap_ta", 16'(ta), 16'h00);
        chk("swap_bank", 16'(ram_bank), 16'h2);
        acc(16'h0155);
        chk("p1_ta", 16'(ta), 16'h01);
        chk("p1_bank", 16'(ram_bank), 16'h0);

        wr(16'hD50A, 8'h03, 1'b1, 1'b1);
        pulse_reset();
        acc(16'h0012);
        chk("rst_p0_ta", 16'(ta), 16'h00);
        chk("rst_p0_bank", 16'(ram_bank), 16'h0);
        wr(16'hD509, 8'h20, 1'b1, 1'b1);
        rd(16'hD50A, 1'b1); chk("shadow_cleared", 16'(dout), 16'h00);
        rd(16'hD509, 1'b1); chk("p1l_rd", 16'(dout), 16'h20);

        // Common RAM
        wr(16'hD506, 8'h07, 1'b1, 1'b1);
        wr(16'hD500, 8'h40, 1'b1, 1'b1);
        acc(16'h0234); chk("cmn_bot", 16'(ram_bank), 16'h0);
        acc(16'h5000); chk("cmn_out", 16'(ram_bank), 16'h1);
        wr(16'hD506, 8'hC8, 1'b1, 1'b1);
        acc(16'hFE00); chk("cmn_top", 16'(ram_bank), 16'h0);
        acc(16'hFB00); chk("cmn_top_out", 16'(ram_bank), 16'h1);
        acc(16'h0234); chk("cmn_bot_off", 16'(ram_bank), 16'h1);
        chk("vic_bank", 16'(vic_bank), 16'h3);
        rd(16'hD506, 1'b1); chk("rcr_rd", 16'(dout), 16'hC8);

        // MCR bits and C64 lockout
        wr(16'hD505, 8'h08, 1'b1, 1'b1);
        chk("fsdir_set", 16'(fsdir), 16'h1);
        chk("z80en_keep", 16'(z80en), 16'h1);
        wr(16'hD505, 8'h41, 1'b1, 1'b1);
        chk("c64_ms3", 16'(ms3), 16'h0);
        chk("c64_z80en", 16'(z80en), 16'h0);
        wr(16'hFF00, 8'h55, 1'b0, 1'b1);
        chk("c64_wr_ignored", 16'(ms2), 16'h0);
        rd(16'hFF00, 1'b0); chk("c64_ff_doe", 16'(doe), 16'h0);
        rd(16'hD500, 1'b1); chk("c64_d5_doe", 16'(doe), 16'h0);
        pulse_reset();
        chk("c64_clr_ms3", 16'(ms3), 16'h1);
        rd(16'hD505, 1'b1); chk("c64_clr_mcr", 16'(dout), 16'h36);

        rd(16'hD50B, 1'b1);
        chk("version", 16'(dout), 16'h20);
        chk("version_doe", 16'(doe), 16'h1);
        rd(16'hD50C, 1'b1); chk("d50c_doe", 16'(doe), 16'h0);
        rd(16'hD500, 1'b0); chk("noiocs_doe", 16'(doe), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmu_8722.md
# mmu_8722

Memory management unit that configures and sequences the 8721 PLA and the DRAM address path. It holds the CPU-visible configuration registers at $D500-$D50B and $FF00-$FF04, and derives the PLA mode inputs ms0..ms3, z80en and the DRAM bank select from them. It also performs page-0/page-1 relocation and common-RAM bank forcing on the translated address. The block sits between the CPU bus, the PLA and the DRAM mux.

## Interface

Parameters:
- VERSION, 8'h20, value returned by reads of $D50B.

Ports:
- clk  in  1  system clock; one CPU access per cycle.
- rst_n  in  1  asynchronous active-low reset.
- a  in  16  CPU address.
- din  in  8  CPU write data.
- rw  in  1  1 = read, 0 = write.
- aec  in  1  1 = CPU owns bus; register access only when 1.
- iocs  in  1  PLA I/O select ($D000-$DFFF visible).
- game, exrom, sw4080  in  1 each  cartridge lines and 40/80 key, MCR readback only.
- dout  out  8  register read data.
- doe  out  1  drive dout onto bus.
- ms0, ms1, ms2, ms3, z80en  out  1 each  PLA mode inputs.
- fsdir  out  1  fast-serial direction, MCR[3].
- ram_bank  out  2  DRAM bank for current access.
- ta  out  8  translated address bits 15:8.
- vic_bank  out  2  VIC RAM bank, RCR[7:6].

## Operation

- Registers: CR (addresses $D500 and $FF00), PCRA-D ($D501-$D504), MCR ($D505), RCR ($D506), P0L/P0H ($D507/$D508), P1L/P1H ($D509/$D50A), and the read-only version register ($D50B).
- Decode:
  - $D5xx hits when iocs=1, a[11:8]=5, a[7:0]<=$0B and c64=0.
  - $FFxx hits when a[15:3]=$1FE0 and a[2:0]<=4 and c64=0.
  - doe=1 only on a read hit.
  - $D50C-$D5FF returns nothing (doe=0).
- LCR: a write to $FF01-$FF04 ignores din and performs CR <= PCR[a-1]. A read of $FF01-$FF04 returns PCR[a-1].
- Page pointers:
  - A write to PxH loads a shadow register only.
  - A write to PxL commits PxL<=din and PxH<=shadow together.
  - Reads return the committed values. The shadow is not readable.
- MCR:
  - bit0 z80sel: 0 = Z80; z80en = ~bit0.
  - bit3 fsdir.
  - bit6 c64.
  - bits 1, 2 read as 1.
  - bits 4, 5, 7 read as game, exrom, sw4080.
- c64 is a one-way latch. Once it is set, all MMU registers become undecoded and writes are ignored; only rst_n clears it. ms3 = ~c64.
- Mode outputs (combinational from registered state and a):
  - a in $4000-$7FFF: {ms1,ms0} = {CR[1],CR[1]}.
  - a in $8000-$BFFF: {ms1,ms0} = CR[3:2].
  - a in $C000-$FFFF: {ms1,ms0} = CR[5:4].
  - Otherwise {ms1,ms0} = 2'b11.
  - ms2 = CR[0].
- Bank and relocation:
  - Default ram_bank = CR[7:6] and ta = a[15:8].
  - Page relocation:
    - If a[15:8]=0: ta=P0L, ram_bank=P0H[1:0].
    - Else if a[15:8]=P0L and P0H[1:0]=CR[7:6]: ta=0.
    - Page 1 follows the same rule with P1L/P1H and page $01. Page 0 is checked first.
  - Common RAM:
    - RCR[1:0] sets the size: 1K, 4K, 8K or 16K.
    - RCR[2] selects the bottom region, RCR[3] the top region.
    - An access inside an enabled region forces ram_bank=0. Common RAM overrides relocation.

## Timing

- A write commits on the rising clk edge where aec=1, rw=0 and the address hits. Outputs reflect the new value from the next cycle.
- Read data is combinational within the same cycle.
- Reset values:
  - CR, PCRA-D, MCR, RCR, P0L, P0H, P1H and both shadows = 0; P1L = 1.
  - dout=0, doe=0.
  - Derived outputs at reset: ms3=1, z80en=1, ms2=0, ram_bank=0, vic_bank=0, fsdir=0.
- Reset asserted mid-sequence (PxH written, PxL not yet written) discards the shadow.
- Writes with aec=0 are ignored.
- A write to an undecoded address changes nothing.

## Test plan

- Reset, then read $D505 with iocs=1, game=1, exrom=1, sw4080=0 -> dout=8'h36, z80en=1, ms3=1.
- Write $D501=8'h3F, then write $FF01 with din=8'h00 -> read $FF00 returns 8'h3F; access at $C123 drives {ms1,ms0}=11, ms2=1.
- Write $D508=2, read $D508 -> 0. Then write $D507=$40 -> $D508 reads 2. An access to $0012 gives ta=$40, ram_bank=2. Then reset and access $0012 again -> ta=$00, ram_bank=0.
- Write RCR=8'h07 and CR=8'h40, then access $0234 -> ram_bank=0; access $5000 -> ram_bank=1.
- Write $D505=8'h41 -> ms3=0. Further writes to $FF00 are ignored and reads give doe=0 until rst_n pulses low.
- Read $D50B -> 8'h20. Read $D50C -> doe=0. Read $D500 with iocs=0 -> doe=0.
